reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register in bits.
REQ-002 Parameter AW, default 3, address width; the register count DEPTH SHALL equal 2**AW.
REQ-003 Parameter R0_ZERO, default 1, when 1 register 0 SHALL read as zero and ignore writes.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  AW  write address.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 ra_addr  input  AW  read port A address.
REQ-010 ra_data  output  WIDTH  read port A data.
REQ-011 ra_busy  output  1  read port A register has a pending write.
REQ-012 rb_addr  input  AW  read port B address.
REQ-013 rb_data  output  WIDTH  read port B data.
REQ-014 rb_busy  output  1  read port B register has a pending write.
REQ-015 busy_set  input  1  mark register busy_addr as pending.
REQ-016 busy_addr  input  AW  register to mark pending.

Function
REQ-017 Storage: DEPTH registers of WIDTH bits, plus one busy bit per register.
REQ-018 Write: if we=1 at the rising edge, reg[waddr] SHALL take wdata; if we=0, all registers SHALL hold.
REQ-019 R0_ZERO=1: writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and busy[0] SHALL never set.
REQ-020 Reads: both ports combinational, independent, and usable with equal addresses in the same cycle.
REQ-021 Bypass: if we=1 and waddr equals a port's address (and is not a zeroed R0), that port SHALL output wdata in the same cycle; otherwise it outputs the stored value.
REQ-022 Busy set: busy_set=1 at the rising edge SHALL set busy[busy_addr].
REQ-023 Busy clear: a write (we=1) at the rising edge SHALL clear busy[waddr].
REQ-024 Set and clear on the same address in the same edge: set SHALL win, meaning busy stays 1 for the new pending operation.
REQ-025 Set and clear on different addresses in the same edge SHALL both take effect.
REQ-026 ra_busy SHALL equal busy[ra_addr] AND NOT (we AND waddr==ra_addr); rb_busy SHALL follow the same rule on port B.
REQ-027 Latency: write to stored value is one edge; write to read port (bypass) is zero cycles; busy_set to *_busy is one edge.
REQ-028 Address range: all AW-bit addresses are valid; no wrap or out-of-range case exists.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, clear all registers to 0 and all busy bits to 0.
REQ-030 While rst=0: ra_data=rb_data=0, ra_busy=rb_busy=0, and we and busy_set SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard any in-progress write or busy_set at that edge.
REQ-032 The first write after rst deasserts SHALL occur at the first rising edge at which rst=1 and we=1.

Verification
REQ-033 Reset then read all addresses on both ports -> every ra_data/rb_data=0 and every busy=0.
REQ-034 Write reg3=0xBEEF, next cycle ra_addr=3, rb_addr=3 -> both ports read 0xBEEF; during the write cycle itself, port A at address 3 -> 0xBEEF via bypass.
REQ-035 R0_ZERO=1: write reg0=0x1234 with busy_set on address 0 -> ra_data(0)=0 and ra_busy=0.
REQ-036 busy_set reg5, then ra_addr=5 -> ra_busy=1; write reg5=0x00A5 -> ra_busy=0 in the write cycle (bypass) and after it.
REQ-037 busy_set reg2 and write reg2=0x0011 on the same edge -> reg2=0x0011 and ra_busy(2)=1 afterwards.
REQ-038 With reg4=0x5555 and busy[4]=1, pull rst low between edges -> ra_data(4)=0 and ra_busy=0 before the next clk edge.

Source files
------------

// File: rtl/reg_file.sv
// Register file with two combinational read ports, write-through bypass and
// per-register pending-write (busy) tracking. Register 0 can be hardwired to zero.
module reg_file #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned AW      = 3,
  parameter int unsigned R0_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam bit          R0Z   = (R0_ZERO != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             wr_en;
  logic             zero_a;
  logic             zero_b;
  logic             hit_a;
  logic             hit_b;

  // Write qualification: a zeroed register 0 swallows writes.
  always_comb begin
    wr_en  = we && !(R0Z && (waddr == '0));
    zero_a = R0Z && (ra_addr == '0);
    zero_b = R0Z && (rb_addr == '0);
    hit_a  = we && (waddr == ra_addr);
    hit_b  = we && (waddr == rb_addr);
  end

  // Next storage contents.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  // Busy set/clear decoders; a set on the same register overrides the clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      set_vec[i] = busy_set && (busy_addr == AW'(i)) && !(R0Z && (i == 0));
      clr_vec[i] = we && (waddr == AW'(i));
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read port A: zeroed R0, then same-cycle bypass, then stored value.
  always_comb begin
    ra_data = '0;
    ra_busy = 1'b0;
    if (rst) begin
      if (zero_a) begin
        ra_data = '0;
      end else if (hit_a) begin
        ra_data = wdata;
      end else begin
        ra_data = mem_q[ra_addr];
      end
      ra_busy = busy_q[ra_addr] && !hit_a;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rb_data = '0;
    rb_busy = 1'b0;
    if (rst) begin
      if (zero_b) begin
        rb_data = '0;
      end else if (hit_b) begin
        rb_data = wdata;
      end else begin
        rb_data = mem_q[rb_addr];
      end
      rb_busy = busy_q[rb_addr] && !hit_b;
    end
  end

endmodule
